// File: rtl/sm4_stream_ctrl_if.sv
// User-side handshakes of the SM4 stream controller: key load, input word stream, result word stream.
// The slave view belongs to the controller and the master view to whatever feeds and drains it.
interface sm4_stream_ctrl_if;
  logic         key_valid;
  logic [127:0] key_in;
  logic         cfg_decrypt;
  logic         key_ready;

  logic         s_valid;
  logic [31:0]  s_data;
  logic         s_last;
  logic         s_ready;

  logic         m_valid;
  logic [31:0]  m_data;
  logic         m_last;
  logic         m_ready;

  modport slave (
    input  key_valid, key_in, cfg_decrypt, s_valid, s_data, s_last, m_ready,
    output key_ready, s_ready, m_valid, m_data, m_last
  );

  modport master (
    output key_valid, key_in, cfg_decrypt, s_valid, s_data, s_last, m_ready,
    input  key_ready, s_ready, m_valid, m_data, m_last
  );
endinterface

// File: rtl/sm4_stream_ctrl.sv
// Streaming front/back end for the SM4 core: key load and expansion, 32->128 bit block packing,
// 128->32 bit result unpacking, and timeout supervision of both core handshakes.
module sm4_stream_ctrl #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  sm4_stream_ctrl_if.slave     strm,
  output logic                 key_loaded,
  output logic                 err_short,
  output logic                 err_timeout,
  output logic                 core_sm4_enable,
  output logic                 core_encdec_enable,
  output logic                 core_encdec_sel,
  output logic                 core_valid,
  output logic [127:0]         core_data,
  output logic                 core_enable_key_exp,
  output logic                 core_user_key_valid,
  output logic [127:0]         core_user_key,
  input  logic                 core_key_exp_ready,
  input  logic                 core_ready,
  input  logic [127:0]         core_result
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] KEY_REQ  = 3'd1;
  localparam logic [2:0] KEY_WAIT = 3'd2;
  localparam logic [2:0] COLLECT  = 3'd3;
  localparam logic [2:0] ENC_REQ  = 3'd4;
  localparam logic [2:0] ENC_WAIT = 3'd5;
  localparam logic [2:0] DRAIN    = 3'd6;

  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [2:0]   state;
  logic [1:0]   wcnt;
  logic [1:0]   ocnt;
  logic [15:0]  tcnt;
  logic [127:0] out_buf;
  logic         blk_last;

  logic         key_rdy;
  logic         s_rdy;
  logic         key_fire;
  logic         s_fire;
  logic         timeout_hit;
  logic [31:0]  out_word;

  // A rekey is only allowed on a block boundary, and it wins over a data word in the same cycle.
  assign key_rdy     = (state == IDLE) || ((state == COLLECT) && (wcnt == 2'd0));
  assign s_rdy       = (state == COLLECT) && !((wcnt == 2'd0) && strm.key_valid);
  assign key_fire    = strm.key_valid && key_rdy;
  assign s_fire      = strm.s_valid && s_rdy;
  assign timeout_hit = (tcnt == TIMEOUT_LAST);

  assign strm.key_ready = key_rdy;
  assign strm.s_ready   = s_rdy;

  assign core_user_key_valid = (state == KEY_REQ);
  assign core_enable_key_exp = (state == KEY_REQ) || (state == KEY_WAIT);
  assign core_valid          = (state == ENC_REQ);
  assign core_encdec_enable  = (state == ENC_REQ) || (state == ENC_WAIT);

  always_comb begin
    out_word = out_buf[127:96];
    case (ocnt)
      2'd0:    out_word = out_buf[127:96];
      2'd1:    out_word = out_buf[95:64];
      2'd2:    out_word = out_buf[63:32];
      default: out_word = out_buf[31:0];
    endcase
  end

  assign strm.m_valid = (state == DRAIN);
  assign strm.m_data  = out_word;
  assign strm.m_last  = (state == DRAIN) && (ocnt == 2'd3) && blk_last;

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      wcnt            <= 2'd0;
      ocnt            <= 2'd0;
      tcnt            <= 16'd0;
      out_buf         <= '0;
      blk_last        <= 1'b0;
      core_data       <= '0;
      core_user_key   <= '0;
      core_encdec_sel <= 1'b0;
      core_sm4_enable <= 1'b0;
      key_loaded      <= 1'b0;
      err_short       <= 1'b0;
      err_timeout     <= 1'b0;
    end else begin
      err_short   <= 1'b0;
      err_timeout <= 1'b0;

      if (key_fire) begin
        core_user_key   <= strm.key_in;
        core_encdec_sel <= strm.cfg_decrypt;
        core_sm4_enable <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (key_fire) state <= KEY_REQ;
        end
        KEY_REQ: begin
          key_loaded <= 1'b0;
          tcnt       <= 16'd0;
          state      <= KEY_WAIT;
        end
        KEY_WAIT: begin
          tcnt <= tcnt + 16'd1;
          if (core_key_exp_ready) begin
            key_loaded <= 1'b1;
            wcnt       <= 2'd0;
            state      <= COLLECT;
          end else if (timeout_hit) begin
            err_timeout <= 1'b1;
            state       <= IDLE;
          end
        end
        COLLECT: begin
          if (key_fire) begin
            state <= KEY_REQ;
          end else if (s_fire) begin
            // The first word of a block clears the rest, so a short block is zero-padded.
            if (wcnt == 2'd0) core_data <= {strm.s_data, 96'd0};
            else core_data[{~wcnt, 5'd0} +: 32] <= strm.s_data;
            wcnt <= wcnt + 2'd1;
            if ((wcnt == 2'd3) || strm.s_last) begin
              blk_last  <= strm.s_last;
              wcnt      <= 2'd0;
              err_short <= strm.s_last && (wcnt != 2'd3);
              state     <= ENC_REQ;
            end
          end
        end
        ENC_REQ: begin
          tcnt  <= 16'd0;
          state <= ENC_WAIT;
        end
        ENC_WAIT: begin
          tcnt <= tcnt + 16'd1;
          if (core_ready) begin
            out_buf <= core_result;
            ocnt    <= 2'd0;
            state   <= DRAIN;
          end else if (timeout_hit) begin
            err_timeout <= 1'b1;
            wcnt        <= 2'd0;
            state       <= COLLECT;
          end
        end
        DRAIN: begin
          if (strm.m_ready) begin
            ocnt <= ocnt + 2'd1;
            if (ocnt == 2'd3) begin
              wcnt  <= 2'd0;
              state <= COLLECT;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sm4_stream_ctrl.sv
// Bench for sm4_stream_ctrl: a stand-in SM4 core, a block-level scoreboard checked every cycle,
// and directed scenarios with literal SM4 reference vectors.
module tb_sm4_stream_ctrl;

  localparam logic [127:0] STD_KEY = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] STD_P   = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] STD_C   = 128'h681edf34d206965e86b3e94f536e4246;

  typedef struct packed { logic [127:0] data; logic dec; } blk_t;
  typedef struct packed { logic [31:0] data; logic last; } word_t;

  logic clk;
  logic reset;
  logic key_valid, cfg_decrypt, key_ready;
  logic [127:0] key_in;
  logic s_valid, s_last, s_ready;
  logic [31:0] s_data;
  logic m_valid, m_last, m_ready;
  logic [31:0] m_data;
  logic key_loaded, err_short, err_timeout;
  logic core_sm4_enable, core_encdec_enable, core_encdec_sel, core_valid;
  logic core_enable_key_exp, core_user_key_valid;
  logic [127:0] core_data, core_user_key, core_result;
  logic core_key_exp_ready, core_ready;

  int total = 0;
  int bad = 0;
  int core_lat = 3;
  int key_lat = 2;
  int err_short_cnt = 0;
  int err_timeout_cnt = 0;
  logic [127:0] cur_key = '0;
  logic cur_dec = 1'b0;

  blk_t        blk_q[$];
  word_t       out_q[$];
  logic [31:0] rx[$];

  sm4_stream_ctrl_if bus ();

  assign bus.key_valid   = key_valid;
  assign bus.key_in      = key_in;
  assign bus.cfg_decrypt = cfg_decrypt;
  assign bus.s_valid     = s_valid;
  assign bus.s_data      = s_data;
  assign bus.s_last      = s_last;
  assign bus.m_ready     = m_ready;
  assign key_ready       = bus.key_ready;
  assign s_ready         = bus.s_ready;
  assign m_valid         = bus.m_valid;
  assign m_data          = bus.m_data;
  assign m_last          = bus.m_last;

  sm4_stream_ctrl #(.TIMEOUT_CYCLES(8)) dut (
    .clk                 (clk),
    .reset               (reset),
    .strm                (bus),
    .key_loaded          (key_loaded),
    .err_short           (err_short),
    .err_timeout         (err_timeout),
    .core_sm4_enable     (core_sm4_enable),
    .core_encdec_enable  (core_encdec_enable),
    .core_encdec_sel     (core_encdec_sel),
    .core_valid          (core_valid),
    .core_data           (core_data),
    .core_enable_key_exp (core_enable_key_exp),
    .core_user_key_valid (core_user_key_valid),
    .core_user_key       (core_user_key),
    .core_key_exp_ready  (core_key_exp_ready),
    .core_ready          (core_ready),
    .core_result         (core_result)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Stand-in cipher: exact on the reference vectors, an arbitrary keyed mapping elsewhere.
  function automatic logic [127:0] core_fn(input logic [127:0] d, input logic [127:0] k, input logic dec);
    if (k == STD_KEY && !dec && d == STD_P) return STD_C;
    if (k == STD_KEY && dec && d == STD_C) return STD_P;
    if (dec) return ~(d ^ k);
    return {d[95:0], d[127:96]} ^ k;
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h want %h", name, actual, expected);
    end
  endtask

  // Core model: key_exp_ready key_lat cycles after the key request, core_ready core_lat cycles after core_valid (0 = never).
  initial begin : core_model
    logic [127:0] model_key, model_data;
    logic model_dec, pend, kpend;
    int ccnt, kcnt;
    model_key = '0; model_data = '0; model_dec = 1'b0;
    pend = 1'b0; kpend = 1'b0; ccnt = 0; kcnt = 0;
    core_ready = 1'b0; core_key_exp_ready = 1'b0; core_result = '0;
    forever begin
      @(negedge clk);
      core_ready = 1'b0;
      core_key_exp_ready = 1'b0;
      if (reset) begin
        pend = 1'b0;
        kpend = 1'b0;
      end else begin
        if (kpend) begin
          kcnt++;
          if (kcnt == key_lat) begin core_key_exp_ready = 1'b1; kpend = 1'b0; end
        end
        if (core_user_key_valid) begin model_key = core_user_key; kpend = 1'b1; kcnt = 0; end
        if (pend) begin
          ccnt++;
          if (ccnt == core_lat) begin
            core_ready = 1'b1;
            core_result = core_fn(model_data, model_key, model_dec);
            pend = 1'b0;
          end
        end
        if (core_valid) begin
          model_data = core_data; model_dec = core_encdec_sel;
          pend = (core_lat != 0); ccnt = 0;
        end
      end
    end
  end

  // Compare process: every cycle, against the expected block and output-word queues.
  initial begin : compare
    logic prev_hold;
    logic [31:0] prev_data;
    blk_t b;
    prev_hold = 1'b0;
    prev_data = '0;
    forever begin
      @(negedge clk);
      #2;
      if (err_short) err_short_cnt++;
      if (err_timeout) err_timeout_cnt++;
      if (!reset) begin
        if (blk_q.size() == 0) checkOutput("core_valid_idle", core_valid, 0);
        else if (core_valid) begin
          b = blk_q.pop_front();
          checkOutput("core_data", core_data, b.data);
          checkOutput("core_encdec_sel", core_encdec_sel, b.dec);
        end
        if (prev_hold) checkOutput("m_hold", {m_valid, m_data}, {1'b1, prev_data});
        if (out_q.size() == 0) checkOutput("m_valid_idle", m_valid, 0);
        else if (m_valid) begin
          checkOutput("m_data", m_data, out_q[0].data);
          checkOutput("m_last", m_last, out_q[0].last);
          checkOutput("s_ready_in_drain", s_ready, 0);
          if (m_ready) begin
            rx.push_back(m_data);
            void'(out_q.pop_front());
          end
        end
        prev_hold = m_valid && !m_ready;
        prev_data = m_data;
      end else begin
        prev_hold = 1'b0;
      end
    end
  end

  task automatic check_reset_values();
    checkOutput("rst_key_ready", key_ready, 1);
    checkOutput("rst_flags", {core_sm4_enable, core_encdec_enable, core_encdec_sel, core_valid,
                              core_enable_key_exp, core_user_key_valid, m_valid, m_last,
                              key_loaded, err_short, err_timeout, s_ready}, 0);
    checkOutput("rst_core_data", core_data, 0);
    checkOutput("rst_core_user_key", core_user_key, 0);
    checkOutput("rst_m_data", m_data, 0);
  endtask

  task automatic load_key(input logic [127:0] key, input logic dec, input logic with_data);
    logic acc;
    logic seen;
    int cyc;
    cur_key = key;
    cur_dec = dec;
    key_valid = 1'b1; key_in = key; cfg_decrypt = dec;
    if (with_data) begin s_valid = 1'b1; s_data = 32'hdeadbeef; s_last = 1'b0; end
    acc = 1'b0;
    for (int c = 0; c < 300 && !acc; c++) begin
      #1;
      if (with_data && c == 0) checkOutput("s_ready_rekey", s_ready, 0);
      if (key_ready) acc = 1'b1;
      @(negedge clk);
    end
    key_valid = 1'b0;
    s_valid = 1'b0;
    checkOutput("key_accept", acc, 1);
    #1;
    checkOutput("core_user_key_valid", core_user_key_valid, 1);
    checkOutput("core_user_key", core_user_key, key);
    checkOutput("core_encdec_sel_key", core_encdec_sel, dec);
    seen = 1'b0;
    cyc = 0;
    for (int c = 1; c <= 50 && !seen; c++) begin
      @(negedge clk);
      #1;
      if (key_loaded) begin seen = 1'b1; cyc = c; end
    end
    checkOutput("key_loaded_latency", cyc, key_lat + 1);
    checkOutput("s_ready_after_key", s_ready, 1);
    @(negedge clk);
  endtask

  // Sends n words of blk (word 0 = bits 127:96) and queues what the controller must produce.
  task automatic applyStimulus(input logic [127:0] blk, input int n, input logic last);
    logic [127:0] exp_blk;
    logic [127:0] res;
    logic acc;
    blk_t b;
    word_t w;
    exp_blk = '0;
    for (int i = 0; i < n; i++) exp_blk[127 - 32*i -: 32] = blk[127 - 32*i -: 32];
    b.data = exp_blk;
    b.dec = cur_dec;
    blk_q.push_back(b);
    if (core_lat != 0) begin
      res = core_fn(exp_blk, cur_key, cur_dec);
      for (int i = 0; i < 4; i++) begin
        w.data = res[127 - 32*i -: 32];
        w.last = last && (i == 3);
        out_q.push_back(w);
      end
    end
    for (int i = 0; i < n; i++) begin
      s_valid = 1'b1;
      s_data = blk[127 - 32*i -: 32];
      s_last = last && (i == n - 1);
      acc = 1'b0;
      for (int c = 0; c < 300 && !acc; c++) begin
        #1;
        if (s_ready) acc = 1'b1;
        @(negedge clk);
      end
      checkOutput("s_accept", acc, 1);
    end
    s_valid = 1'b0;
    s_last = 1'b0;
  endtask

  task automatic wait_drain();
    for (int c = 0; c < 300; c++) begin
      if (out_q.size() == 0 && blk_q.size() == 0 && !m_valid) break;
      @(negedge clk);
    end
    checkOutput("drain_done", {out_q.size() == 0, m_valid}, {1'b1, 1'b0});
  endtask

  task automatic check_words(input string name, input logic [127:0] exp);
    checkOutput({name, "_count"}, rx.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < rx.size()) checkOutput(name, rx[i], exp[127 - 32*i -: 32]);
  endtask

  initial begin : main
    int sc, tc;
    logic seen;
    reset = 1'b1;
    key_valid = 1'b0; key_in = '0; cfg_decrypt = 1'b0;
    s_valid = 1'b0; s_data = '0; s_last = 1'b0;
    m_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check_reset_values();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    $display("[TB] standard vector, encrypt");
    load_key(STD_KEY, 1'b0, 1'b0);
    rx.delete();
    applyStimulus(STD_P, 4, 1'b1);
    wait_drain();
    check_words("enc_word", STD_C);

    $display("[TB] short block");
    sc = err_short_cnt;
    rx.delete();
    applyStimulus(128'haabbccdd_11223344_55667788_99aabbcc, 2, 1'b1);
    wait_drain();
    checkOutput("err_short_pulses", err_short_cnt - sc, 1);
    checkOutput("short_rx_count", rx.size(), 4);

    $display("[TB] backpressure");
    rx.delete();
    applyStimulus(128'h10203040_50607080_90a0b0c0_d0e0f000, 4, 1'b0);
    seen = 1'b0;
    for (int c = 0; c < 100 && !seen; c++) begin
      if (m_valid) seen = 1'b1;
      else @(negedge clk);
    end
    checkOutput("bp_m_valid_seen", seen, 1);
    @(negedge clk);
    m_ready = 1'b0;
    repeat (10) begin
      #1;
      checkOutput("bp_s_ready", s_ready, 0);
      checkOutput("bp_m_valid", m_valid, 1);
      @(negedge clk);
    end
    m_ready = 1'b1;
    wait_drain();
    checkOutput("bp_rx_count", rx.size(), 4);

    $display("[TB] rekey priority, standard vector decrypt");
    load_key(STD_KEY, 1'b1, 1'b1);
    rx.delete();
    applyStimulus(STD_C, 4, 1'b1);
    wait_drain();
    check_words("dec_word", STD_P);

    $display("[TB] core never ready");
    core_lat = 0;
    tc = err_timeout_cnt;
    applyStimulus(128'hcafef00d_01020304_a5a5a5a5_5a5a5a5a, 4, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      #1;
      checkOutput("no_early_timeout", err_timeout, 0);
    end
    @(negedge clk);
    #1;
    checkOutput("err_timeout_pulse", err_timeout, 1);
    checkOutput("s_ready_after_timeout", s_ready, 1);
    checkOutput("m_valid_after_timeout", m_valid, 0);
    @(negedge clk);
    checkOutput("timeout_count", err_timeout_cnt - tc, 1);

    $display("[TB] core ready on the last allowed cycle");
    core_lat = 8;
    tc = err_timeout_cnt;
    rx.delete();
    applyStimulus(128'h0badf00d_11111111_22222222_33333333, 4, 1'b1);
    wait_drain();
    checkOutput("late_ready_no_timeout", err_timeout_cnt - tc, 0);
    checkOutput("late_ready_rx_count", rx.size(), 4);

    $display("[TB] reset during ENC_WAIT");
    core_lat = 0;
    tc = err_timeout_cnt;
    applyStimulus(STD_P, 4, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #1;
    check_reset_values();
    @(negedge clk);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    checkOutput("no_timeout_after_reset", err_timeout_cnt - tc, 0);
    checkOutput("idle_after_reset", key_ready, 1);

    $display("[TB] recovery after reset");
    core_lat = 3;
    load_key(STD_KEY, 1'b0, 1'b0);
    rx.delete();
    applyStimulus(STD_P, 4, 1'b1);
    wait_drain();
    check_words("recover_word", STD_C);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/sm4_stream_ctrl.md
# sm4_stream_ctrl

Streaming front/back end for the SM4 core (`sm4_top`). It sits directly upstream and downstream of the core. On the input side it loads a 128-bit user key and runs key expansion, then packs a 32-bit valid/ready word stream into 128-bit blocks and issues each block to the core. On the output side it captures each result and unpacks it into a 32-bit valid/ready stream. It also adds timeout supervision on both core handshakes.

## Interface
- `TIMEOUT_CYCLES`, default 1024. Maximum number of cycles to wait for `core_key_exp_ready` or `core_ready` before aborting. Legal range is 2..65535.
- `clk` in 1: the single clock. Everything is synchronous to its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `cfg_decrypt` in 1: direction select; 1 = decrypt. Sampled together with the key.
- `key_valid` in 1, `key_in` in 128, `key_ready` out 1: key load handshake.
- `s_valid` in 1, `s_data` in 32, `s_last` in 1, `s_ready` out 1: plaintext/ciphertext input word stream.
- `m_valid` out 1, `m_data` out 32, `m_last` out 1, `m_ready` in 1: result word stream.
- `key_loaded` out 1: round keys are valid.
- `err_short` out 1: one-cycle pulse when a block was zero-padded.
- `err_timeout` out 1: one-cycle pulse when a core handshake timed out.
- Core-facing outputs, which drive the like-named `sm4_top` inputs:
  - `core_sm4_enable` out 1
  - `core_encdec_enable` out 1
  - `core_encdec_sel` out 1
  - `core_valid` out 1
  - `core_data` out 128
  - `core_enable_key_exp` out 1
  - `core_user_key_valid` out 1
  - `core_user_key` out 128
- Core-facing inputs:
  - `core_key_exp_ready` in 1
  - `core_ready` in 1
  - `core_result` in 128

## Operation
- **FSM states:** IDLE, KEY_REQ, KEY_WAIT, COLLECT, ENC_REQ, ENC_WAIT, DRAIN.
- **Word order:** big-endian. Word 0 maps to bits [127:96] and word 3 to bits [31:0]. The same order applies to packing and unpacking.
- **IDLE:**
  - `key_ready`=1.
  - On `key_valid` && `key_ready`: latch `key_in` into `core_user_key` and `cfg_decrypt` into `core_encdec_sel`, then go to KEY_REQ.
  - `core_sm4_enable` is set here and stays 1 until reset.
- **KEY_REQ (1 cycle):**
  - `core_user_key_valid`=1 and `core_enable_key_exp`=1.
  - Clear `key_loaded`, then go to KEY_WAIT.
- **KEY_WAIT:**
  - `core_enable_key_exp` is held at 1.
  - On `core_key_exp_ready`: set `key_loaded`=1 and go to COLLECT.
  - On timeout: pulse `err_timeout` and go to IDLE with `key_loaded`=0.
- **COLLECT:**
  - `s_ready` = !(wcnt==0 && `key_valid`).
  - Each accepted word goes into slot wcnt, and wcnt increments. wcnt is 2 bits.
  - When wcnt==3 is accepted, or `s_last` is accepted, go to ENC_REQ. The block's last flag = `s_last`.
  - If `s_last` arrives with wcnt<3: the remaining slots are zero and `err_short` pulses in the cycle after acceptance.
- **Rekey:**
  - `key_ready`=1 in COLLECT only while wcnt==0.
  - A key handshake there goes to KEY_REQ.
  - A key has priority over a data word in the same cycle; `s_ready` is 0 that cycle.
- **ENC_REQ (1 cycle):** `core_valid`=1 with `core_data` = the packed block, then go to ENC_WAIT.
- **core_encdec_enable:** 1 during ENC_REQ and ENC_WAIT, 0 otherwise.
- **ENC_WAIT:**
  - On `core_ready`: capture `core_result` into the output buffer and go to DRAIN.
  - On timeout: pulse `err_timeout`, drop the block, clear wcnt, and go to COLLECT. No output is produced.
- **DRAIN:**
  - `m_valid`=1 and `m_data` = output buffer word ocnt.
  - `m_last` = (ocnt==3) && block last flag.
  - ocnt advances on `m_ready`.
  - After word 3 is accepted: wcnt=0, go to COLLECT.
  - A short block still emits 4 words.
- **Timeout counter:** 16-bit. It clears on entry to KEY_WAIT or ENC_WAIT and increments each cycle in those states. Timeout fires when count == `TIMEOUT_CYCLES`-1 and the awaited ready signal is 0. A ready arriving on that same cycle wins.
- **Rekey and key validity:** `key_ready` is 0 in KEY_REQ, KEY_WAIT, ENC_REQ, ENC_WAIT and DRAIN. A key change never affects an in-flight block.

## Timing
- **Reset values:**
  - All outputs are 0, except `key_ready`=1 because the state is IDLE.
  - The state is IDLE, all counters are 0, and the buffers are 0.
  - A reset mid-operation discards any in-flight key or block, with no output.
- **Registered and combinational outputs:**
  - All core-facing outputs, `m_*`, `err_*` and `key_loaded` are registered or decoded from registered state only.
  - `s_ready` and `key_ready` have a combinational dependency on `key_valid` and state only.
- **Latency:**
  - 4th word accepted at cycle t gives `core_valid` at t+1.
  - `core_ready` at t+1+L (L≥1) gives `m_valid` at t+2+L.
  - With `m_ready` tied high, the 4 output words occupy t+2+L..t+5+L.
  - The next `s_ready` is at t+6+L.
- **Key load:** key handshake at cycle k gives `core_user_key_valid` at k+1. `key_loaded` rises one cycle after `core_key_exp_ready`, as does `s_ready`.
- **Ordering:** one block is in flight at a time. Blocks are never reordered.

## Test plan
- **Standard vector, encrypt:** load key 0123456789abcdeffedcba9876543210 with `cfg_decrypt`=0, then send words 01234567, 89abcdef, fedcba98, 76543210 with `s_last` on the 4th. Expect `m_data` 681edf34, d206965e, 86b3e94f, 536e4246, with `m_last` on the 4th.
- **Standard vector, decrypt:** `cfg_decrypt`=1, same key, input 681edf34..536e4246. Expect output 01234567..76543210.
- **Short block:** send 2 words with `s_last` on the 2nd. Expect `core_data`[63:0]=0, one `err_short` pulse, and 4 output words with `m_last` on the 4th.
- **Backpressure:** hold `m_ready` at 0 for 10 cycles mid-DRAIN. Expect `m_data`/`m_valid` stable and `s_ready`=0 throughout. No word is lost or duplicated.
- **Timeout:** `TIMEOUT_CYCLES`=8 and a core model that never asserts `core_ready`. Expect `err_timeout` 8 cycles after entering ENC_WAIT, no `m_valid`, and `s_ready`=1 on the next cycle. Repeat with `core_ready` arriving on the 8th cycle: no timeout.
- **Rekey priority and reset:** `key_valid` and `s_valid` both high with wcnt==0. Expect the key to be accepted, `s_ready`=0, and `key_loaded` to drop then rise after `core_key_exp_ready`. Separately, assert `reset` during ENC_WAIT: all outputs return to their reset values the next cycle.
